pipe_control: RTL and testbench
===============================

PIPE_CONTROL -- requirements
Module: pipe_control

Interface
REQ-001 Parameter STAT_W, default 3, width of stage status codes.
REQ-002 Parameter CNT_W, default 32, width of performance counters.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 D_icode, E_icode, M_icode  in  4 each  icode held in the D, E and M pipeline registers.
REQ-006 E_dstM  in  4  memory destination register of the E-stage instruction.
REQ-007 d_srcA, d_srcB  in  4 each  source registers being decoded.
REQ-008 e_Cnd  in  1  branch condition computed in execute.
REQ-009 m_stat, W_stat  in  STAT_W each  status leaving memory and held in write-back.
REQ-010 F_stall, D_stall, W_stall  out  1 each  hold the stage register.
REQ-011 D_bubble, E_bubble, M_bubble  out  1 each  load a nop (icode 4'h1, ifun 4'h0) into the stage register.
REQ-012 set_cc  out  1  permit condition-code update.
REQ-013 cpu_stat  out  STAT_W  latched processor status.
REQ-014 halted  out  1  processor stopped.
REQ-015 cyc_cnt, stall_cnt, flush_cnt  out  CNT_W each  performance counters (present only with PIPE_PERF_CNT_EN).

Function
REQ-016 Codes: IRRMOVQ..: HALT 0, NOP 1, OPQ 6, JXX 7, MRMOVQ 5, RET 9, POPQ B; RNONE F; stat AOK 1, HLT 2, ADR 3, INS 4.
REQ-017 State machine states FLUSH, RUN, STOPPED; state is the only registered control; all stall/bubble outputs are combinational from state and inputs (zero latency).
REQ-018 FLUSH: F_stall=1, D_bubble=E_bubble=M_bubble=1, all others 0; next state RUN unconditionally (one cycle).
REQ-019 RUN, load-use = E_icode in {MRMOVQ,POPQ} and E_dstM != RNONE and E_dstM equals d_srcA or d_srcB.
REQ-020 RUN, ret_pend = RET in any of D_icode, E_icode, M_icode; mispredict = E_icode==JXX and !e_Cnd.
REQ-021 RUN: F_stall = load-use | ret_pend; D_stall = load-use; D_bubble = mispredict | (ret_pend & !load-use); E_bubble = mispredict | load-use.
REQ-022 RUN: exc_m = m_stat in {HLT,ADR,INS}; exc_w = W_stat in {HLT,ADR,INS}; M_bubble = exc_m | exc_w; W_stall = exc_w; set_cc = E_icode==OPQ & !exc_m & !exc_w.
REQ-023 D_stall and D_bubble SHALL never both be 1; load-use with mispredict yields D_stall=0, D_bubble=1, E_bubble=1, F_stall=1 (mispredict wins over stall for D).
REQ-024 RUN to STOPPED when exc_w; cpu_stat latches W_stat on that edge; halted=1 from next cycle.
REQ-025 STOPPED: F_stall=D_stall=W_stall=1, E_bubble=M_bubble=1, D_bubble=0, set_cc=0; held until reset.
REQ-026 cpu_stat stays AOK while RUN; values other than AOK..INS on W_stat treated as AOK.

Reset
REQ-027 rst_n low at a posedge: state=FLUSH, cpu_stat=AOK, halted=0, counters=0; reset mid-operation (incl. STOPPED) overrides all transitions.
REQ-028 Outputs during and in the cycle after reset take FLUSH values per REQ-018.

Configuration
REQ-029 PIPE_PERF_CNT_EN defined: cyc_cnt +1 each RUN cycle, stall_cnt +1 each RUN cycle with F_stall, flush_cnt +1 each RUN cycle with mispredict; wrap at 2^CNT_W; frozen in STOPPED.
REQ-030 PIPE_PERF_CNT_EN undefined: counter ports and registers absent; all other behaviour identical.

Structure
REQ-031 Package pipe_pkg holds icode, register-ID and stat constants and the FLUSH/RUN/STOPPED state encoding.
REQ-032 Combinational sub-module pipe_hazard_detect computes load-use, ret_pend, mispredict, exc_m, exc_w; pipe_control owns state, cpu_stat and counters.

Verification
REQ-033 Reset: rst_n=0 one cycle -> FLUSH outputs, next cycle all stall/bubble 0 with NOP icodes, cpu_stat=1.
REQ-034 Load-use: E_icode=5, E_dstM=3, d_srcA=3 -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0.
REQ-035 Ret: D_icode=9 for 3 successive cycles (D,E,M) -> F_stall=1 and D_bubble=1 each cycle.
REQ-036 Mispredict plus load-use same cycle: E_icode=7 e_Cnd=0 -> D_bubble=1, E_bubble=1, D_stall=0.
REQ-037 Exception: m_stat=3 -> M_bubble=1, set_cc=0; next cycle W_stat=3 -> W_stall=1, then cpu_stat=3, halted=1, outputs per REQ-025 until rst_n=0.
REQ-038 Counters (macro on): 10 RUN cycles with 2 load-use -> cyc_cnt=10, stall_cnt=2; preload near 2^CNT_W-1 -> wraps to 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared encodings for the five-stage pipeline control slice.
// Holds icode, register-ID and status constants plus the control FSM encoding.
// Used by pipe_control and pipe_hazard_detect.
package pipe_pkg;

  // Instruction codes as held in the stage registers
  localparam logic [3:0] I_HALT    = 4'h0;
  localparam logic [3:0] I_NOP     = 4'h1;
  localparam logic [3:0] I_IRRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ  = 4'h3;
  localparam logic [3:0] I_RMMOVQ  = 4'h4;
  localparam logic [3:0] I_MRMOVQ  = 4'h5;
  localparam logic [3:0] I_OPQ     = 4'h6;
  localparam logic [3:0] I_JXX     = 4'h7;
  localparam logic [3:0] I_CALL    = 4'h8;
  localparam logic [3:0] I_RET     = 4'h9;
  localparam logic [3:0] I_PUSHQ   = 4'hA;
  localparam logic [3:0] I_POPQ    = 4'hB;

  // Register ID meaning "no register"
  localparam logic [3:0] R_NONE = 4'hF;

  // Status codes; kept as integers so they can be sized to any STAT_W
  localparam int unsigned STAT_AOK = 1;
  localparam int unsigned STAT_HLT = 2;
  localparam int unsigned STAT_ADR = 3;
  localparam int unsigned STAT_INS = 4;

  // Control FSM encoding
  typedef enum logic [1:0] {
    ST_FLUSH   = 2'd0,
    ST_RUN     = 2'd1,
    ST_STOPPED = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_hazard_detect.sv
// Pure combinational hazard and exception classification for the pipeline.
// Zero latency; no state, no handshake.
// Consumed by pipe_control, which turns these terms into stall/bubble controls.
module pipe_hazard_detect
  import pipe_pkg::*;
#(
  parameter int STAT_W = 3
) (
  input  logic [3:0]        D_icode,
  input  logic [3:0]        E_icode,
  input  logic [3:0]        M_icode,
  input  logic [3:0]        E_dstM,
  input  logic [3:0]        d_srcA,
  input  logic [3:0]        d_srcB,
  input  logic              e_Cnd,
  input  logic [STAT_W-1:0] m_stat,
  input  logic [STAT_W-1:0] W_stat,
  output logic              load_use,
  output logic              ret_pend,
  output logic              mispredict,
  output logic              exc_m,
  output logic              exc_w
);

  // Only HLT/ADR/INS stop the machine; AOK and any unknown code are benign
  function automatic logic is_exc(input logic [STAT_W-1:0] s);
    return (s == STAT_W'(STAT_HLT)) || (s == STAT_W'(STAT_ADR)) ||
           (s == STAT_W'(STAT_INS));
  endfunction

  logic e_is_load;

  // Classify the current hazards from the stage register contents
  always_comb begin
    e_is_load  = (E_icode == I_MRMOVQ) || (E_icode == I_POPQ);
    load_use   = e_is_load && (E_dstM != R_NONE) &&
                 ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    ret_pend   = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
    mispredict = (E_icode == I_JXX) && !e_Cnd;
    exc_m      = is_exc(m_stat);
    exc_w      = is_exc(W_stat);
  end

endmodule

// File: rtl/pipe_control.sv
// Pipeline control: FLUSH/RUN/STOPPED FSM driving stall/bubble, cpu_stat, halted.
// Controls are combinational from state and inputs (zero latency); state is the only registered control.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_control
  import pipe_pkg::*;
#(
  parameter int STAT_W = 3,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        D_icode,
  input  logic [3:0]        E_icode,
  input  logic [3:0]        M_icode,
  input  logic [3:0]        E_dstM,
  input  logic [3:0]        d_srcA,
  input  logic [3:0]        d_srcB,
  input  logic              e_Cnd,
  input  logic [STAT_W-1:0] m_stat,
  input  logic [STAT_W-1:0] W_stat,
  output logic              F_stall,
  output logic              D_stall,
  output logic              W_stall,
  output logic              D_bubble,
  output logic              E_bubble,
  output logic              M_bubble,
  output logic              set_cc,
  output logic [STAT_W-1:0] cpu_stat,
  output logic              halted
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  cyc_cnt,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  state_t state;
  state_t state_nxt;

  logic load_use;
  logic ret_pend;
  logic mispredict;
  logic exc_m;
  logic exc_w;

  pipe_hazard_detect #(
    .STAT_W (STAT_W)
  ) u_hazard (
    .D_icode    (D_icode),
    .E_icode    (E_icode),
    .M_icode    (M_icode),
    .E_dstM     (E_dstM),
    .d_srcA     (d_srcA),
    .d_srcB     (d_srcB),
    .e_Cnd      (e_Cnd),
    .m_stat     (m_stat),
    .W_stat     (W_stat),
    .load_use   (load_use),
    .ret_pend   (ret_pend),
    .mispredict (mispredict),
    .exc_m      (exc_m),
    .exc_w      (exc_w)
  );

  // State register; reset wins over every transition, including from STOPPED
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_FLUSH;
    else        state <= state_nxt;
  end

  // Next state and stage controls; while rst_n is low the FLUSH controls are
  // presented so the pipeline is already being cleared during reset
  always_comb begin
    state_nxt = state;
    F_stall   = 1'b0;
    D_stall   = 1'b0;
    W_stall   = 1'b0;
    D_bubble  = 1'b0;
    E_bubble  = 1'b0;
    M_bubble  = 1'b0;
    set_cc    = 1'b0;
    case (rst_n ? state : ST_FLUSH)
      ST_FLUSH: begin
        F_stall   = 1'b1;
        D_bubble  = 1'b1;
        E_bubble  = 1'b1;
        M_bubble  = 1'b1;
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        F_stall  = load_use | ret_pend;
        // A mispredicted branch squashes D, so it overrides a load-use hold
        D_stall  = load_use & !mispredict;
        D_bubble = mispredict | (ret_pend & !load_use);
        E_bubble = mispredict | load_use;
        M_bubble = exc_m | exc_w;
        W_stall  = exc_w;
        set_cc   = (E_icode == I_OPQ) & !exc_m & !exc_w;
        if (exc_w) state_nxt = ST_STOPPED;
      end
      ST_STOPPED: begin
        F_stall  = 1'b1;
        D_stall  = 1'b1;
        W_stall  = 1'b1;
        E_bubble = 1'b1;
        M_bubble = 1'b1;
      end
      default: begin
        state_nxt = ST_FLUSH;
      end
    endcase
  end

  // Latch the faulting write-back status on the edge that enters STOPPED
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cpu_stat <= STAT_W'(STAT_AOK);
      halted   <= 1'b0;
    end else if (state == ST_RUN && exc_w) begin
      cpu_stat <= W_stat;
      halted   <= 1'b1;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  // Performance counters advance only in RUN, wrap naturally, freeze in STOPPED
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc_cnt   <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (state == ST_RUN) begin
      cyc_cnt <= cyc_cnt + CNT_W'(1);
      if (F_stall)    stall_cnt <= stall_cnt + CNT_W'(1);
      if (mispredict) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_control.sv
// Self-checking bench for pipe_control: table of RUN-state vectors plus
// hand-written reset, exception/STOPPED and counter sequences.
// Counter checks are compiled when PIPE_PERF_CNT_EN is defined.
module tb_pipe_control;

  localparam int STAT_W = 3;
  localparam int CNT_W  = 4;

  // Control vector order: {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc}
  localparam logic [6:0] O_ZERO  = 7'b0000000;
  localparam logic [6:0] O_FLUSH = 7'b1011100;
  localparam logic [6:0] O_STOP  = 7'b1101110;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [3:0]        D_icode, E_icode, M_icode, E_dstM, d_srcA, d_srcB;
  logic              e_Cnd;
  logic [STAT_W-1:0] m_stat, W_stat;
  logic              F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, set_cc;
  logic [STAT_W-1:0] cpu_stat;
  logic              halted;
`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0]  cyc_cnt, stall_cnt, flush_cnt;
`endif

  pipe_control #(
    .STAT_W (STAT_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .D_icode  (D_icode),
    .E_icode  (E_icode),
    .M_icode  (M_icode),
    .E_dstM   (E_dstM),
    .d_srcA   (d_srcA),
    .d_srcB   (d_srcB),
    .e_Cnd    (e_Cnd),
    .m_stat   (m_stat),
    .W_stat   (W_stat),
    .F_stall  (F_stall),
    .D_stall  (D_stall),
    .W_stall  (W_stall),
    .D_bubble (D_bubble),
    .E_bubble (E_bubble),
    .M_bubble (M_bubble),
    .set_cc   (set_cc),
    .cpu_stat (cpu_stat),
    .halted   (halted)
`ifdef PIPE_PERF_CNT_EN
    ,
    .cyc_cnt   (cyc_cnt),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [6:0] ctl;
  assign ctl = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc};

  typedef struct packed {
    logic [3:0] d_ic;
    logic [3:0] e_ic;
    logic [3:0] m_ic;
    logic [3:0] dstm;
    logic [3:0] sa;
    logic [3:0] sb;
    logic       cnd;
    logic [2:0] ms;
    logic [2:0] ws;
    logic [6:0] exp;
  } vec_t;

  localparam int NVEC = 20;
  vec_t vecs [NVEC];

  logic [6:0] sb_q [$];
  int checks   = 0;
  int failures = 0;

  task automatic apply(input vec_t v);
    D_icode = v.d_ic; E_icode = v.e_ic; M_icode = v.m_ic;
    E_dstM  = v.dstm; d_srcA  = v.sa;   d_srcB  = v.sb;
    e_Cnd   = v.cnd;  m_stat  = v.ms;   W_stat  = v.ws;
  endtask

  task automatic neutral();
    D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1;
    E_dstM  = 4'hF; d_srcA  = 4'hF; d_srcB  = 4'hF;
    e_Cnd   = 1'b1; m_stat  = 3'd1; W_stat  = 3'd1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Push the expected control word, then pop and compare at the falling edge
  task automatic check_ctl(input string name, input logic [6:0] expv);
    logic [6:0] want;
    sb_q.push_back(expv);
    @(negedge clk);
    want = sb_q.pop_front();
    checks++;
    if (ctl !== want) begin
      failures++;
      $display("FAIL %s: ctl got %b want %b (F D Db Eb Mb W cc)", name, ctl, want);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            D     E     M     dstM  sA    sB    cnd   ms    ws    F D Db Eb Mb W cc
    vecs[0]  = '{4'h1, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 3'd1, 3'd1, 7'b0000000};
    vecs[1]  = '{4'h1, 4'h5, 4'h1, 4'h3, 4'h3, 4'hF, 1'b1, 3'd1, 3'd1, 7'b1101000};
    vecs[2]  = '{4'h1, 4'hB, 4'h1, 4'h4, 4'hF, 4'h4, 1'b1, 3'd1, 3'd1, 7'b1101000};
    vecs[3]  = '{4'h1, 4'h5, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 3'd1, 3'd1, 7'b0000000};
    vecs[4]  = '{4'h1, 4'h5, 4'h1, 4'h3, 4'h2, 4'h4, 1'b1, 3'd1, 3'd1, 7'b0000000};
    vecs[5]  = '{4'h1, 4'h2, 4'h1, 4'h3, 4'h3, 4'h3, 1'b1, 3'd1, 3'd1, 7'b0000000};
    vecs[6]  = '{4'h9, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 3'd1, 3'd1, 7'b1010000};
    vecs[7]  = '{4'h1, 4'h9, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 3'd1, 3'd1, 7'b1010000};
    vecs[8]  = '{4'h1, 4'h1, 4'h9, 4'hF, 4'hF, 4'hF, 1'b1, 3'd1, 3'd1, 7'b1010000};
    vecs[9]  = '{4'h9, 4'h5, 4'h1, 4'h3, 4'h3, 4'hF, 1'b1, 3'd1, 3'd1, 7'b1101000};
    vecs[10] = '{4'h1, 4'h7, 4'h1, 4'h3, 4'h3, 4'hF, 1'b0, 3'd1, 3'd1, 7'b0011000};
    vecs[11] = '{4'h1, 4'h7, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 3'd1, 3'd1, 7'b0000000};
    vecs[12] = '{4'h9, 4'h7, 4'h1, 4'hF, 4'hF, 4'hF, 1'b0, 3'd1, 3'd1, 7'b1011000};
    vecs[13] = '{4'h1, 4'h6, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 3'd1, 3'd1, 7'b0000001};
    vecs[14] = '{4'h1, 4'h6, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 3'd2, 3'd1, 7'b0000100};
    vecs[15] = '{4'h1, 4'h6, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 3'd4, 3'd1, 7'b0000100};
    vecs[16] = '{4'h1, 4'h6, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 3'd0, 3'd1, 7'b0000001};
    vecs[17] = '{4'h1, 4'h6, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 3'd5, 3'd0, 7'b0000001};
    vecs[18] = '{4'h1, 4'h6, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 3'd1, 3'd7, 7'b0000001};
    vecs[19] = '{4'h1, 4'h5, 4'h1, 4'h3, 4'h3, 4'hF, 1'b1, 3'd3, 3'd1, 7'b1101100};

    // Reset: FLUSH controls during reset and in the cycle after
    rst_n = 1'b0;
    neutral();
    check_ctl("rst_during", O_FLUSH);
    step();
    rst_n = 1'b1;
    check_ctl("flush_after_rst", O_FLUSH);
    check_val("rst_cpu_stat", 32'(cpu_stat), 1);
    check_val("rst_halted", 32'(halted), 0);
    step();
    check_ctl("run_idle", O_ZERO);
    check_val("run_cpu_stat", 32'(cpu_stat), 1);

    // RUN-state vector table (no write-back exception, so stays in RUN)
    for (int i = 0; i < NVEC; i++) begin
      apply(vecs[i]);
      check_ctl($sformatf("vec%0d", i), vecs[i].exp);
      check_val($sformatf("vec%0d_cpu_stat", i), 32'(cpu_stat), 1);
      step();
    end

    // Exception in M, then in W, then STOPPED until reset
    neutral();
    E_icode = 4'h6; m_stat = 3'd3;
    check_ctl("exc_m", 7'b0000100);
    step();
    m_stat = 3'd1; W_stat = 3'd3;
    check_ctl("exc_w", 7'b0000110);
    check_val("exc_w_halted", 32'(halted), 0);
    check_val("exc_w_cpu_stat", 32'(cpu_stat), 1);
    step();
    neutral();
    E_icode = 4'h7; e_Cnd = 1'b0;
    check_ctl("stopped0", O_STOP);
    check_val("stopped_cpu_stat", 32'(cpu_stat), 3);
    check_val("stopped_halted", 32'(halted), 1);
    step();
    neutral();
    E_icode = 4'h5; E_dstM = 4'h2; d_srcB = 4'h2; W_stat = 3'd2;
    check_ctl("stopped1", O_STOP);
    check_val("stopped1_cpu_stat", 32'(cpu_stat), 3);
    step();
    neutral();
    rst_n = 1'b0;
    check_ctl("rst_from_stopped", O_FLUSH);
    step();
    rst_n = 1'b1;
    check_ctl("flush_after_stop", O_FLUSH);
    check_val("rst2_cpu_stat", 32'(cpu_stat), 1);
    check_val("rst2_halted", 32'(halted), 0);
    step();
    check_ctl("run_after_stop", O_ZERO);

`ifdef PIPE_PERF_CNT_EN
    // Counters: fresh reset, 10 RUN cycles with 2 load-use and 1 mispredict
    rst_n = 1'b0;
    neutral();
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check_val("cnt_rst_cyc", 32'(cyc_cnt), 0);
    check_val("cnt_rst_stall", 32'(stall_cnt), 0);
    step();
    for (int i = 0; i < 10; i++) begin
      neutral();
      if (i == 2 || i == 6) begin
        E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
      end
      if (i == 4) begin
        E_icode = 4'h7; e_Cnd = 1'b0;
      end
      step();
    end
    neutral();
    @(negedge clk);
    check_val("cnt_cyc10", 32'(cyc_cnt), 10);
    check_val("cnt_stall2", 32'(stall_cnt), 2);
    check_val("cnt_flush1", 32'(flush_cnt), 1);
    for (int i = 0; i < 5; i++) step();
    @(negedge clk);
    check_val("cnt_cyc15", 32'(cyc_cnt), 15);
    step();
    @(negedge clk);
    check_val("cnt_wrap", 32'(cyc_cnt), 0);
    // Enter STOPPED: the exc_w cycle is still a RUN cycle, then frozen
    W_stat = 3'd4;
    step();
    neutral();
    step();
    step();
    @(negedge clk);
    check_val("cnt_frozen", 32'(cyc_cnt), 1);
    check_val("cnt_frozen_stat", 32'(cpu_stat), 4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
